// File: rtl/alu_arb_if.sv
// Bundle between the two ALU requesters, the arbiter and the shared ALU.
// The master side is the environment (requesters plus ALU); the slave side is the arbiter.
interface alu_arb_if #(parameter int DATA_WIDTH = 16);

   logic                  r0_req;
   logic                  r0_log;
   logic [1:0]            r0_hc;
   logic [2:0]            r0_sc;
   logic                  r0_sat;
   logic [DATA_WIDTH-1:0] r0_dtx;
   logic [DATA_WIDTH-1:0] r0_dty;
   logic                  r0_gnt;
   logic                  r0_done;

   logic                  r1_req;
   logic                  r1_log;
   logic [1:0]            r1_hc;
   logic [2:0]            r1_sc;
   logic                  r1_sat;
   logic [DATA_WIDTH-1:0] r1_dtx;
   logic [DATA_WIDTH-1:0] r1_dty;
   logic                  r1_gnt;
   logic                  r1_done;

   logic [DATA_WIDTH-1:0] arb_dt;
   logic                  arb_az;
   logic                  arb_an;
   logic                  arb_ac;
   logic                  arb_av;
   logic                  arb_busy;

   logic                  ps_alu_en;
   logic                  ps_alu_log;
   logic [1:0]            ps_alu_hc;
   logic [2:0]            ps_alu_sc;
   logic                  ps_alu_sat;
   logic [DATA_WIDTH-1:0] xb_dtx;
   logic [DATA_WIDTH-1:0] xb_dty;

   logic [DATA_WIDTH-1:0] alu_xb_dt;
   logic                  alu_ps_az;
   logic                  alu_ps_an;
   logic                  alu_ps_ac;
   logic                  alu_ps_av;

   modport master (
      output r0_req, r0_log, r0_hc, r0_sc, r0_sat, r0_dtx, r0_dty,
      output r1_req, r1_log, r1_hc, r1_sc, r1_sat, r1_dtx, r1_dty,
      output alu_xb_dt, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av,
      input  r0_gnt, r0_done, r1_gnt, r1_done,
      input  arb_dt, arb_az, arb_an, arb_ac, arb_av, arb_busy,
      input  ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, xb_dtx, xb_dty
   );

   modport slave (
      input  r0_req, r0_log, r0_hc, r0_sc, r0_sat, r0_dtx, r0_dty,
      input  r1_req, r1_log, r1_hc, r1_sc, r1_sat, r1_dtx, r1_dty,
      input  alu_xb_dt, alu_ps_az, alu_ps_an, alu_ps_ac, alu_ps_av,
      output r0_gnt, r0_done, r1_gnt, r1_done,
      output arb_dt, arb_az, arb_an, arb_ac, arb_av, arb_busy,
      output ps_alu_en, ps_alu_log, ps_alu_hc, ps_alu_sc, ps_alu_sat, xb_dtx, xb_dty
   );

endinterface

// File: rtl/alu_arb.sv
// Two-requester round-robin arbiter in front of a shared ALU: one operation
// per four cycles (IDLE, ISSUE, EXEC, DONE), result and flags captured locally.
module alu_arb #(
   parameter int DATA_WIDTH = 16
) (
   input logic      clk,
   input logic      reset,
   alu_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      EXEC  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   logic                  owner;
   logic                  last_served;
   logic                  any_req;
   logic                  pick;

   logic                  op_log;
   logic [1:0]            op_hc;
   logic [2:0]            op_sc;
   logic                  op_sat;
   logic [DATA_WIDTH-1:0] op_dtx;
   logic [DATA_WIDTH-1:0] op_dty;

   logic [DATA_WIDTH-1:0] res_dt;
   logic                  res_az;
   logic                  res_an;
   logic                  res_ac;
   logic                  res_av;

   logic                  gnt0;
   logic                  gnt1;
   logic                  done0;
   logic                  done1;
   logic                  alu_en;

   assign any_req = bus.r0_req | bus.r1_req;

   // On a tie the requester that was not served last wins.
   always_comb begin
      pick = 1'b0;
      if (bus.r0_req && bus.r1_req) begin
         pick = ~last_served;
      end else if (bus.r1_req) begin
         pick = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      done0      = 1'b0;
      done1      = 1'b0;
      alu_en     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            alu_en     = 1'b1;
            gnt0       = ~owner;
            gnt1       = owner;
            next_state = EXEC;
         end
         EXEC: begin
            next_state = DONE;
         end
         DONE: begin
            done0      = ~owner;
            done1      = owner;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Reset leaves last_served at 1 so r0 takes the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner       <= 1'b0;
         last_served <= 1'b1;
         op_log      <= 1'b0;
         op_hc       <= '0;
         op_sc       <= '0;
         op_sat      <= 1'b0;
         op_dtx      <= '0;
         op_dty      <= '0;
      end else if (state == IDLE && any_req) begin
         owner       <= pick;
         last_served <= pick;
         op_log      <= pick ? bus.r1_log : bus.r0_log;
         op_hc       <= pick ? bus.r1_hc  : bus.r0_hc;
         op_sc       <= pick ? bus.r1_sc  : bus.r0_sc;
         op_sat      <= pick ? bus.r1_sat : bus.r0_sat;
         op_dtx      <= pick ? bus.r1_dtx : bus.r0_dtx;
         op_dty      <= pick ? bus.r1_dty : bus.r0_dty;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_dt <= '0;
         res_az <= 1'b0;
         res_an <= 1'b0;
         res_ac <= 1'b0;
         res_av <= 1'b0;
      end else if (state == EXEC) begin
         res_dt <= bus.alu_xb_dt;
         res_az <= bus.alu_ps_az;
         res_an <= bus.alu_ps_an;
         res_ac <= bus.alu_ps_ac;
         res_av <= bus.alu_ps_av;
      end
   end

   assign bus.r0_gnt     = gnt0;
   assign bus.r1_gnt     = gnt1;
   assign bus.r0_done    = done0;
   assign bus.r1_done    = done1;
   assign bus.arb_busy   = (state != IDLE);
   assign bus.ps_alu_en  = alu_en;
   assign bus.ps_alu_log = op_log;
   assign bus.ps_alu_hc  = op_hc;
   assign bus.ps_alu_sc  = op_sc;
   assign bus.ps_alu_sat = op_sat;
   assign bus.xb_dtx     = op_dtx;
   assign bus.xb_dty     = op_dty;
   assign bus.arb_dt     = res_dt;
   assign bus.arb_az     = res_az;
   assign bus.arb_an     = res_an;
   assign bus.arb_ac     = res_ac;
   assign bus.arb_av     = res_av;

endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb with a small behavioural ALU behind it.
module tb_alu_arb;

   logic clk;
   logic reset;

   alu_arb_if #(.DATA_WIDTH(16)) bus ();

   alu_arb #(.DATA_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [15:0] dt;
      logic [3:0]  flags;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // ALU model: operands latched on the enable strobe, saturation applied live.
   logic        a_log;
   logic [2:0]  a_sc;
   logic [15:0] a_x;
   logic [15:0] a_y;
   logic [16:0] a_sum;
   logic [15:0] a_res;
   logic        a_c;
   logic        a_v;

   initial begin
      a_log = 1'b0;
      a_sc  = 3'd0;
      a_x   = 16'h0;
      a_y   = 16'h0;
   end

   always @(posedge clk) begin
      if (bus.ps_alu_en) begin
         a_log <= bus.ps_alu_log;
         a_sc  <= bus.ps_alu_sc;
         a_x   <= bus.xb_dtx;
         a_y   <= bus.xb_dty;
      end
   end

   always_comb begin
      a_sum = 17'h0;
      a_res = 16'h0;
      a_c   = 1'b0;
      a_v   = 1'b0;
      if (a_log) begin
         a_res = a_x & a_y;
      end else if (a_sc == 3'd0) begin
         a_sum = {1'b0, a_x} + {1'b0, a_y};
         a_res = a_sum[15:0];
         a_c   = a_sum[16];
         a_v   = (a_x[15] == a_y[15]) && (a_res[15] != a_x[15]);
      end else if (a_sc == 3'd1) begin
         a_sum = {1'b0, a_x} + {1'b0, ~a_y} + 17'd1;
         a_res = a_sum[15:0];
         a_c   = a_sum[16];
         a_v   = (a_x[15] != a_y[15]) && (a_res[15] != a_x[15]);
      end else begin
         a_res = a_x;
      end
      if (a_v && bus.ps_alu_sat) begin
         a_res = a_x[15] ? 16'h8000 : 16'h7FFF;
      end
      bus.alu_xb_dt = a_res;
      bus.alu_ps_az = (a_res == 16'h0);
      bus.alu_ps_an = a_res[15];
      bus.alu_ps_ac = a_c;
      bus.alu_ps_av = a_v;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic id, input logic req, input logic log_f,
                                input logic [1:0] hc, input logic [2:0] sc, input logic sat,
                                input logic [15:0] x, input logic [15:0] y);
      if (id == 1'b0) begin
         bus.r0_req = req; bus.r0_log = log_f; bus.r0_hc = hc; bus.r0_sc = sc;
         bus.r0_sat = sat; bus.r0_dtx = x; bus.r0_dty = y;
      end else begin
         bus.r1_req = req; bus.r1_log = log_f; bus.r1_hc = hc; bus.r1_sc = sc;
         bus.r1_sat = sat; bus.r1_dtx = x; bus.r1_dty = y;
      end
   endtask

   task automatic pushExp(input logic id, input logic [15:0] dt, input logic [3:0] flags);
      exp_t e;
      e.id    = id;
      e.dt    = dt;
      e.flags = flags;
      sb.push_back(e);
   endtask

   // One isolated operation from requester id, with cycle-by-cycle timing checks.
   task automatic runSingle(input logic id, input logic log_f, input logic [1:0] hc,
                            input logic [2:0] sc, input logic sat,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] exp_dt, input logic [3:0] exp_flags);
      applyStimulus(id, 1'b1, log_f, hc, sc, sat, x, y);
      pushExp(id, exp_dt, exp_flags);
      @(negedge clk);
      checkOutput("issue_gnt_owner", id ? bus.r1_gnt : bus.r0_gnt, 1);
      checkOutput("issue_gnt_other", id ? bus.r0_gnt : bus.r1_gnt, 0);
      checkOutput("issue_alu_en", bus.ps_alu_en, 1);
      checkOutput("issue_ctrl", {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc, bus.ps_alu_sat},
                  {log_f, hc, sc, sat});
      checkOutput("issue_operands", {bus.xb_dtx, bus.xb_dty}, {x, y});
      applyStimulus(id, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("exec_alu_en", bus.ps_alu_en, 0);
      checkOutput("exec_gnt", {bus.r0_gnt, bus.r1_gnt}, 0);
      checkOutput("exec_sat_held", bus.ps_alu_sat, sat);
      checkOutput("exec_operands_held", {bus.xb_dtx, bus.xb_dty}, {x, y});
      @(negedge clk);
      checkOutput("done_owner", id ? bus.r1_done : bus.r0_done, 1);
      checkOutput("done_other", id ? bus.r0_done : bus.r1_done, 0);
      checkOutput("done_busy", bus.arb_busy, 1);
      @(negedge clk);
      checkOutput("idle_busy", bus.arb_busy, 0);
      checkOutput("idle_dt_held", bus.arb_dt, exp_dt);
      checkOutput("idle_done", {bus.r0_done, bus.r1_done}, 0);
   endtask

   // Scoreboard monitor: every done pulse consumes one expected result.
   always @(negedge clk) begin
      exp_t e;
      if (bus.r0_done || bus.r1_done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: got r0=%0d r1=%0d expected none", bus.r0_done, bus.r1_done);
         end else begin
            e = sb.pop_front();
            checkOutput("sb_owner", {bus.r1_done, bus.r0_done}, e.id ? 2'b10 : 2'b01);
            checkOutput("sb_dt", bus.arb_dt, e.dt);
            checkOutput("sb_flags", {bus.arb_az, bus.arb_an, bus.arb_ac, bus.arb_av}, e.flags);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0, 16'h0);
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", bus.arb_busy, 0);
      checkOutput("rst_gnt_done", {bus.r0_gnt, bus.r1_gnt, bus.r0_done, bus.r1_done}, 0);
      checkOutput("rst_alu_en", bus.ps_alu_en, 0);
      checkOutput("rst_ctrl", {bus.ps_alu_log, bus.ps_alu_hc, bus.ps_alu_sc, bus.ps_alu_sat}, 0);
      checkOutput("rst_operands", {bus.xb_dtx, bus.xb_dty}, 0);
      checkOutput("rst_result", {bus.arb_dt, bus.arb_az, bus.arb_an, bus.arb_ac, bus.arb_av}, 0);

      // Request applied with the reset release is sampled on the very next edge.
      reset = 1'b1;
      runSingle(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0003, 16'h0004, 16'h0007, 4'b0000);
      runSingle(1'b1, 1'b0, 2'd0, 3'd1, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b1010);
      runSingle(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 4'b0001);
      runSingle(1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 16'h8000, 16'h0001, 16'h8001, 4'b0100);
      runSingle(1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000);
      runSingle(1'b1, 1'b0, 2'd3, 3'd7, 1'b0, 16'h1357, 16'h2468, 16'h1357, 4'b0000);

      // Both requesters held continuously straight after a reset pulse.
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("pulse_rst_result", bus.arb_dt, 0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0001, 16'h0001);
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0010, 16'h0020);
      pushExp(1'b0, 16'h0002, 4'b0000);
      pushExp(1'b1, 16'h0030, 4'b0000);
      pushExp(1'b0, 16'h0002, 4'b0000);
      pushExp(1'b1, 16'h0030, 4'b0000);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         checkOutput($sformatf("rr_r0_gnt_c%0d", c), bus.r0_gnt, (c % 8) == 1);
         checkOutput($sformatf("rr_r1_gnt_c%0d", c), bus.r1_gnt, (c % 8) == 5);
         checkOutput($sformatf("rr_busy_c%0d", c), bus.arb_busy, (c % 4) != 0);
         checkOutput($sformatf("rr_r0_done_c%0d", c), bus.r0_done, (c % 8) == 3);
         checkOutput($sformatf("rr_r1_done_c%0d", c), bus.r1_done, (c % 8) == 7);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0, 16'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      checkOutput("rr_idle_after", bus.arb_busy, 0);

      // Abort an operation with reset while it is in EXEC.
      applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0002, 16'h0002);
      @(negedge clk);
      checkOutput("abort_gnt", bus.r1_gnt, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("abort_busy", bus.arb_busy, 0);
      checkOutput("abort_result", {bus.arb_dt, bus.arb_az, bus.arb_an, bus.arb_ac, bus.arb_av}, 0);
      checkOutput("abort_operands", {bus.xb_dtx, bus.xb_dty, bus.ps_alu_en}, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("abort_quiet_%0d", c), {bus.r0_done, bus.r1_done, bus.arb_busy}, 0);
      end
      runSingle(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 16'h1234, 16'h0001, 16'h1235, 4'b0000);

      checkOutput("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
